// File: rtl/csr_trap_ctrl_if.sv
// Execute-side op handshake and writeback/redirect response bundle for csr_trap_ctrl.
interface csr_trap_ctrl_if #(
  parameter int XLEN = 64
);
  logic            in_valid;
  logic            in_ready;
  logic [2:0]      in_op;
  logic [XLEN-1:0] in_pc;
  logic [XLEN-1:0] in_src;
  logic [11:0]     in_csr;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] rd_data;
  logic            rd_wen;
  logic            redir_valid;
  logic [XLEN-1:0] redir_pc;

  modport master (
    output in_valid, in_op, in_pc, in_src, in_csr, out_ready,
    input  in_ready, out_valid, rd_data, rd_wen, redir_valid, redir_pc
  );

  modport slave (
    input  in_valid, in_op, in_pc, in_src, in_csr, out_ready,
    output in_ready, out_valid, rd_data, rd_wen, redir_valid, redir_pc
  );
endinterface

// File: rtl/csr_trap_ctrl.sv
// SYSTEM-op sequencer in front of the CSR file: CSR read-modify-write, ECALL/illegal traps, MRET.
// Optional CSR_TRAP_CNT_EN adds a 32-bit trap_count output counting TRAP cycles.
//
// state   | meaning
// IDLE    | in_ready high, waiting for an op
// READ    | csr_raddr presented, old value captured
// WRITE   | single-cycle CSR write (suppressed for set/clear with zero mask)
// TRAP    | single-cycle mepc/mcause write, trap vector captured
// RESP    | result held on out_* until out_ready
module csr_trap_ctrl #(
  parameter int XLEN          = 64,
  parameter int ECALL_CAUSE   = 11,
  parameter int ILLEGAL_CAUSE = 2
) (
  input  logic            clk,
  input  logic            rst,
  csr_trap_ctrl_if.slave  bus,
  output logic [11:0]     csr_raddr,
  input  logic [XLEN-1:0] csr_rdata,
  output logic [11:0]     csr_waddr,
  output logic [XLEN-1:0] csr_wdata,
  output logic [XLEN-1:0] mcause_in,
  output logic            mcause_wen,
  output logic [XLEN-1:0] mepc_in,
  output logic            mepc_wen,
  input  logic [XLEN-1:0] mtvec,
  input  logic [XLEN-1:0] mepc
`ifdef CSR_TRAP_CNT_EN
  ,
  output logic [31:0]     trap_count
`endif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_WRITE,
    S_TRAP,
    S_RESP
  } state_t;

  localparam logic [2:0] OP_CSRRW = 3'd0;
  localparam logic [2:0] OP_CSRRS = 3'd1;
  localparam logic [2:0] OP_CSRRC = 3'd2;
  localparam logic [2:0] OP_ECALL = 3'd3;
  localparam logic [2:0] OP_MRET  = 3'd4;
  localparam logic [XLEN-1:0] VEC_MASK = ~XLEN'(3);

  state_t          state;
  logic [2:0]      op_q;
  logic [XLEN-1:0] src_q;
  logic [11:0]     csr_q;
  logic [XLEN-1:0] old_q;
  logic [XLEN-1:0] wdata_next;
  logic            in_is_csr;

  assign in_is_csr = (bus.in_op == OP_CSRRW) || (bus.in_op == OP_CSRRS) ||
                     (bus.in_op == OP_CSRRC);

  always_comb begin
    wdata_next = src_q;
    case (op_q)
      OP_CSRRS: wdata_next = csr_rdata | src_q;
      OP_CSRRC: wdata_next = csr_rdata & ~src_q;
      default:  wdata_next = src_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state           <= S_IDLE;
      op_q            <= '0;
      src_q           <= '0;
      csr_q           <= '0;
      old_q           <= '0;
      csr_raddr       <= '0;
      csr_waddr       <= 12'h000;
      csr_wdata       <= '0;
      mcause_in       <= '0;
      mcause_wen      <= 1'b0;
      mepc_in         <= '0;
      mepc_wen        <= 1'b0;
      bus.in_ready    <= 1'b1;
      bus.out_valid   <= 1'b0;
      bus.rd_data     <= '0;
      bus.rd_wen      <= 1'b0;
      bus.redir_valid <= 1'b0;
      bus.redir_pc    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.in_valid) begin
            op_q         <= bus.in_op;
            src_q        <= bus.in_src;
            csr_q        <= bus.in_csr;
            bus.in_ready <= 1'b0;
            if (in_is_csr) begin
              csr_raddr <= bus.in_csr;
              state     <= S_READ;
            end else if (bus.in_op == OP_MRET) begin
              bus.redir_pc    <= mepc;
              bus.redir_valid <= 1'b1;
              bus.rd_wen      <= 1'b0;
              bus.out_valid   <= 1'b1;
              state           <= S_RESP;
            end else begin
              mepc_in    <= bus.in_pc;
              mepc_wen   <= 1'b1;
              mcause_in  <= (bus.in_op == OP_ECALL) ? XLEN'(ECALL_CAUSE) : XLEN'(ILLEGAL_CAUSE);
              mcause_wen <= 1'b1;
              state      <= S_TRAP;
            end
          end
        end
        S_READ: begin
          old_q     <= csr_rdata;
          csr_wdata <= wdata_next;
          // set/clear with an all-zero mask must not touch the CSR (side-effect free read)
          if ((op_q == OP_CSRRW) || (src_q != '0))
            csr_waddr <= csr_q;
          state <= S_WRITE;
        end
        S_WRITE: begin
          csr_waddr       <= 12'h000;
          bus.rd_data     <= old_q;
          bus.rd_wen      <= 1'b1;
          bus.redir_valid <= 1'b0;
          bus.out_valid   <= 1'b1;
          state           <= S_RESP;
        end
        S_TRAP: begin
          mepc_wen        <= 1'b0;
          mcause_wen      <= 1'b0;
          bus.redir_pc    <= mtvec & VEC_MASK;
          bus.redir_valid <= 1'b1;
          bus.rd_wen      <= 1'b0;
          bus.out_valid   <= 1'b1;
          state           <= S_RESP;
        end
        S_RESP: begin
          if (bus.out_ready) begin
            bus.out_valid   <= 1'b0;
            bus.rd_wen      <= 1'b0;
            bus.redir_valid <= 1'b0;
            bus.in_ready    <= 1'b1;
            state           <= S_IDLE;
          end
        end
        default: begin
          csr_waddr       <= 12'h000;
          mepc_wen        <= 1'b0;
          mcause_wen      <= 1'b0;
          bus.out_valid   <= 1'b0;
          bus.rd_wen      <= 1'b0;
          bus.redir_valid <= 1'b0;
          bus.in_ready    <= 1'b1;
          state           <= S_IDLE;
        end
      endcase
    end
  end

`ifdef CSR_TRAP_CNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      trap_count <= '0;
    else if (state == S_TRAP)
      trap_count <= trap_count + 32'd1;
  end
`endif

endmodule

// File: tb/tb_csr_trap_ctrl.sv
// Self-checking bench for csr_trap_ctrl: directed vector table, reset/backpressure sequences
// and randomized ops checked against an op-semantics reference model.
module tb_csr_trap_ctrl;
  localparam int XLEN = 64;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [11:0]     csr_raddr;
  logic [XLEN-1:0] csr_rdata;
  logic [11:0]     csr_waddr;
  logic [XLEN-1:0] csr_wdata;
  logic [XLEN-1:0] mcause_in;
  logic            mcause_wen;
  logic [XLEN-1:0] mepc_in;
  logic            mepc_wen;
  logic [XLEN-1:0] mtvec = '0;
  logic [XLEN-1:0] mepc = '0;
`ifdef CSR_TRAP_CNT_EN
  logic [31:0]     trap_count;
`endif

  logic [11:0]     cur_csr = 12'h001;
  logic [XLEN-1:0] cur_old = '0;
  int              n_checks = 0;
  int              n_fail = 0;

  always #5 clk = ~clk;

  csr_trap_ctrl_if #(.XLEN(XLEN)) bus ();

  // CSR file stub: only the op's own CSR returns the expected old value
  assign csr_rdata = (csr_raddr == cur_csr) ? cur_old : ~cur_old;

  csr_trap_ctrl #(.XLEN(XLEN), .ECALL_CAUSE(11), .ILLEGAL_CAUSE(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .csr_raddr  (csr_raddr),
    .csr_rdata  (csr_rdata),
    .csr_waddr  (csr_waddr),
    .csr_wdata  (csr_wdata),
    .mcause_in  (mcause_in),
    .mcause_wen (mcause_wen),
    .mepc_in    (mepc_in),
    .mepc_wen   (mepc_wen),
    .mtvec      (mtvec),
    .mepc       (mepc)
`ifdef CSR_TRAP_CNT_EN
    ,
    .trap_count (trap_count)
`endif
  );

  typedef struct {
    logic [2:0]  op;
    logic [11:0] csr;
    logic [63:0] src;
    logic [63:0] old;
    logic [63:0] pc;
    logic [63:0] mtvec;
    logic [63:0] mepc;
    int          hold;
    int          exp_lat;
    logic        exp_write;
    logic [63:0] exp_wdata;
    logic        exp_rd_wen;
    logic        exp_trap;
    logic [63:0] exp_cause;
    logic        exp_redir;
    logic [63:0] exp_redir_pc;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mkv(input logic [2:0] op, input logic [11:0] csr, input logic [63:0] src,
                               input logic [63:0] old, input logic [63:0] pc, input logic [63:0] tv,
                               input logic [63:0] ep, input int hold, input int lat, input logic w,
                               input logic [63:0] wd, input logic rdw, input logic trap,
                               input logic [63:0] cause, input logic redir, input logic [63:0] rpc);
    vec_t v;
    v.op = op; v.csr = csr; v.src = src; v.old = old; v.pc = pc; v.mtvec = tv; v.mepc = ep;
    v.hold = hold; v.exp_lat = lat; v.exp_write = w; v.exp_wdata = wd; v.exp_rd_wen = rdw;
    v.exp_trap = trap; v.exp_cause = cause; v.exp_redir = redir; v.exp_redir_pc = rpc;
    return v;
  endfunction

  // Reference model: expected results derived from the architectural meaning of each op
  function automatic vec_t model(input vec_t v);
    vec_t r = v;
    r.exp_write = 0; r.exp_wdata = 0; r.exp_rd_wen = 0; r.exp_trap = 0;
    r.exp_cause = 0; r.exp_redir = 0; r.exp_redir_pc = 0;
    case (v.op)
      3'd0: begin r.exp_lat = 3; r.exp_rd_wen = 1; r.exp_write = 1; r.exp_wdata = v.src; end
      3'd1: begin r.exp_lat = 3; r.exp_rd_wen = 1; r.exp_write = (v.src != 0); r.exp_wdata = v.old | v.src; end
      3'd2: begin r.exp_lat = 3; r.exp_rd_wen = 1; r.exp_write = (v.src != 0); r.exp_wdata = v.old & ~v.src; end
      3'd3: begin r.exp_lat = 2; r.exp_trap = 1; r.exp_cause = 11; r.exp_redir = 1; r.exp_redir_pc = (v.mtvec / 4) * 4; end
      3'd4: begin r.exp_lat = 1; r.exp_redir = 1; r.exp_redir_pc = v.mepc; end
      default: begin r.exp_lat = 2; r.exp_trap = 1; r.exp_cause = 2; r.exp_redir = 1; r.exp_redir_pc = (v.mtvec / 4) * 4; end
    endcase
    return r;
  endfunction

  task automatic run_vec(input vec_t v);
    int lat, wcnt, mecnt, mccnt, both, guard;
    logic [63:0] waddr_s, wdata_s, mepc_s, cause_s;
    logic got;
    waddr_s = 0; wdata_s = 0; mepc_s = 0; cause_s = 0;
    wcnt = 0; mecnt = 0; mccnt = 0; both = 0; got = 0;
    cur_csr = v.csr; cur_old = v.old; mtvec = v.mtvec; mepc = v.mepc;
    @(negedge clk);
    guard = 0;
    while (!bus.in_ready && guard < 20) begin @(negedge clk); guard++; end
    check("in_ready_idle", bus.in_ready, 1);
    bus.in_valid = 1; bus.in_op = v.op; bus.in_pc = v.pc; bus.in_src = v.src; bus.in_csr = v.csr;
    @(negedge clk);
    bus.in_valid = 0; bus.in_op = 3'($urandom); bus.in_pc = {$urandom, $urandom};
    bus.in_src = {$urandom, $urandom}; bus.in_csr = 12'($urandom);
    lat = 1;
    while (lat <= 8) begin
      if (csr_waddr != 12'h000) begin wcnt++; waddr_s = 64'(csr_waddr); wdata_s = csr_wdata; end
      if (mepc_wen) begin mecnt++; mepc_s = mepc_in; end
      if (mcause_wen) begin mccnt++; cause_s = mcause_in; end
      if (mepc_wen && mcause_wen) both++;
      if (bus.out_valid) begin got = 1; break; end
      @(negedge clk);
      lat++;
    end
    check("out_valid_seen", got, 1);
    if (!got) return;
    check("latency", lat, v.exp_lat);
    check("csr_write_pulses", wcnt, v.exp_write ? 1 : 0);
    if (v.exp_write) begin
      check("csr_waddr", waddr_s, 64'(v.csr));
      check("csr_wdata", wdata_s, v.exp_wdata);
    end
    check("mepc_wen_pulses", mecnt, v.exp_trap ? 1 : 0);
    check("mcause_wen_pulses", mccnt, v.exp_trap ? 1 : 0);
    if (v.exp_trap) begin
      check("trap_pulses_together", both, 1);
      check("mepc_in", mepc_s, v.pc);
      check("mcause_in", cause_s, v.exp_cause);
    end
    check("resp_in_ready", bus.in_ready, 0);
    check("rd_wen", bus.rd_wen, v.exp_rd_wen);
    if (v.exp_rd_wen) check("rd_data", bus.rd_data, v.old);
    check("redir_valid", bus.redir_valid, v.exp_redir);
    if (v.exp_redir) check("redir_pc", bus.redir_pc, v.exp_redir_pc);
    bus.out_ready = 0;
    for (int i = 0; i < v.hold; i++) begin
      @(negedge clk);
      check("resp_hold_ctl",
            {57'd0, bus.out_valid, bus.rd_wen, bus.redir_valid, bus.in_ready, |csr_waddr, mepc_wen, mcause_wen},
            {57'd0, 1'b1, v.exp_rd_wen, v.exp_redir, 4'b0000});
      if (v.exp_rd_wen) check("resp_hold_rd_data", bus.rd_data, v.old);
      if (v.exp_redir) check("resp_hold_redir_pc", bus.redir_pc, v.exp_redir_pc);
    end
    bus.out_ready = 1;
    @(negedge clk);
    bus.out_ready = 0;
    check("out_valid_drop", bus.out_valid, 0);
    check("in_ready_back", bus.in_ready, 1);
  endtask

  vec_t tbl[10];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t r;
    tbl[0] = mkv(3'd0, 12'h305, 64'h80000100, 64'h0, 64'h1000, 0, 0, 0, 3, 1, 64'h80000100, 1, 0, 0, 0, 0);
    tbl[1] = mkv(3'd1, 12'h342, 64'h0F, 64'hF0, 64'h1004, 0, 0, 1, 3, 1, 64'hFF, 1, 0, 0, 0, 0);
    tbl[2] = mkv(3'd1, 12'h342, 64'h0, 64'hF0, 64'h1008, 0, 0, 0, 3, 0, 64'h0, 1, 0, 0, 0, 0);
    tbl[3] = mkv(3'd2, 12'h300, 64'h0F, 64'hFF, 64'h100C, 0, 0, 2, 3, 1, 64'hF0, 1, 0, 0, 0, 0);
    tbl[4] = mkv(3'd2, 12'h300, 64'h0, 64'hAA, 64'h1010, 0, 0, 0, 3, 0, 64'h0, 1, 0, 0, 0, 0);
    tbl[5] = mkv(3'd3, 12'h7C0, 64'h5, 64'h0, 64'h80000010, 64'h80000203, 0, 0, 2, 0, 0, 0, 1, 11, 1, 64'h80000200);
    tbl[6] = mkv(3'd4, 12'h7C1, 64'h0, 64'h0, 64'h2000, 64'h300, 64'h80000014, 0, 1, 0, 0, 0, 0, 0, 1, 64'h80000014);
    tbl[7] = mkv(3'd7, 12'h7C2, 64'h0, 64'h0, 64'h1234, 64'h100, 0, 5, 2, 0, 0, 0, 1, 2, 1, 64'h100);
    tbl[8] = mkv(3'd5, 12'h7C3, 64'h0, 64'h0, 64'h55, 64'hFFFFFFFFFFFFFFFF, 0, 0, 2, 0, 0, 0, 1, 2, 1, 64'hFFFFFFFFFFFFFFFC);
    tbl[9] = mkv(3'd0, 12'hFFF, 64'h0, 64'h1234, 64'h2004, 0, 0, 5, 3, 1, 64'h0, 1, 0, 0, 0, 0);

    bus.in_valid = 0; bus.in_op = 0; bus.in_pc = 0; bus.in_src = 0; bus.in_csr = 0; bus.out_ready = 0;
    repeat (2) @(negedge clk);
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_csr_waddr", 64'(csr_waddr), 0);
    check("rst_wen", {62'd0, mepc_wen, mcause_wen}, 0);
    check("rst_rd_redir", {62'd0, bus.rd_wen, bus.redir_valid}, 0);
    rst = 1;

    for (int i = 0; i < 10; i++) run_vec(tbl[i]);

    // reset asserted while a CSRRW sits in WRITE
    @(negedge clk);
    cur_csr = 12'h305; cur_old = 64'h77;
    bus.in_valid = 1; bus.in_op = 3'd0; bus.in_src = 64'hABCD; bus.in_csr = 12'h305; bus.in_pc = 0;
    @(negedge clk);
    bus.in_valid = 0;
    @(negedge clk);
    check("pre_rst_write_cycle", 64'(csr_waddr), 64'h305);
    #1 rst = 0;
    #1;
    check("mid_rst_out_valid", bus.out_valid, 0);
    check("mid_rst_csr_waddr", 64'(csr_waddr), 0);
    check("mid_rst_in_ready", bus.in_ready, 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_held_quiet", {61'd0, |csr_waddr, bus.out_valid, mepc_wen}, 0);
    end
    rst = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("post_rst_idle", {60'd0, |csr_waddr, bus.out_valid, mepc_wen, bus.in_ready}, 1);
    end

`ifdef CSR_TRAP_CNT_EN
    check("trap_count_zero", 64'(trap_count), 0);
    for (int i = 0; i < 3; i++) run_vec(tbl[5]);
    check("trap_count_three", 64'(trap_count), 3);
`endif

    for (int i = 0; i < 40; i++) begin
      r.op = 3'($urandom_range(0, 7));
      r.csr = 12'($urandom_range(1, 4095));
      r.src = ($urandom_range(0, 3) == 0) ? 64'h0 : {$urandom, $urandom};
      r.old = {$urandom, $urandom};
      r.pc = {$urandom, $urandom};
      r.mtvec = {$urandom, $urandom};
      r.mepc = {$urandom, $urandom};
      r.hold = $urandom_range(0, 3);
      r.exp_lat = 0;
      run_vec(model(r));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
